// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath sizing for the CPU core.
//   WORD_WIDTH - bits per architectural register
//   REG_COUNT  - number of general-purpose registers
//   REG_ADDR_W - bits needed to index REG_COUNT registers
package cpu_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_read_port.sv
// register_file_read_port: one registered read port of the register file.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   mem_flat     - flattened storage, word i at [i*WIDTH +: WIDTH]
//   writeEnable, writeAddr, writeData - current write, used for forwarding
//   readAddr     - register index sampled at the rising edge
//   readData     - registered result, valid one cycle after readAddr
module register_file_read_port #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  input  logic                   writeEnable,
  input  logic [ADDR_W-1:0]      writeAddr,
  input  logic [WIDTH-1:0]       writeData,
  input  logic [ADDR_W-1:0]      readAddr,
  output logic [WIDTH-1:0]       readData
);

  logic [WIDTH-1:0] words [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_unflat
    assign words[g] = mem_flat[g*WIDTH +: WIDTH];
  end

  // Zero check comes first so a write to register 0 is never forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData <= '0;
    end else if (readAddr == '0) begin
      readData <= '0;
    end else if (writeEnable && (writeAddr == readAddr)) begin
      readData <= writeData;
    end else begin
      readData <= words[readAddr];
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file: two-read, one-write general-purpose register file.
// Ports:
//   clk                  - single clock, rising edge
//   reset                - synchronous active-high, clears storage and outputs
//   writeEnable/Addr/Data - write-back port, stored at the rising edge
//   readAddrA, readDataA - read port A, one-cycle registered latency
//   readAddrB, readDataB - read port B, one-cycle registered latency
// Register 0 has no storage and always reads as zero; same-cycle writes are
// forwarded to readers of the same register.
module register_file
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = REG_COUNT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [WIDTH-1:0]  writeData,
  input  logic [ADDR_W-1:0] readAddrA,
  output logic [WIDTH-1:0]  readDataA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [WIDTH-1:0]  readDataB
);

  logic [WIDTH-1:0]       mem [1:DEPTH-1];
  logic [DEPTH*WIDTH-1:0] mem_flat;

  // Slot 0 of the bus is tied off; there is no flop behind register 0.
  assign mem_flat[WIDTH-1:0] = '0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*WIDTH +: WIDTH] = mem[g];
  end

  // Per-entry decode; address 0 matches no entry, so its writes vanish.
  always_ff @(posedge clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (reset) begin
        mem[i] <= '0;
      end else if (writeEnable && (writeAddr == ADDR_W'(i))) begin
        mem[i] <= writeData;
      end
    end
  end

  register_file_read_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .clk         (clk),
    .reset       (reset),
    .mem_flat    (mem_flat),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .readAddr    (readAddrA),
    .readData    (readDataA)
  );

  register_file_read_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .clk         (clk),
    .reset       (reset),
    .mem_flat    (mem_flat),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .readAddr    (readAddrB),
    .readData    (readDataB)
  );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: self-checking bench for register_file.
// Each driven cycle pushes its expected port A/B values to a queue; after the
// clock edge the entry is popped and compared against the registered outputs.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [4:0]  readAddrA;
  logic [31:0] readDataA;
  logic [4:0]  readAddrB;
  logic [31:0] readDataB;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    string       tag;
  } vec_t;

  logic [31:0] model [32];

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .readAddrA   (readAddrA),
    .readDataA   (readDataA),
    .readAddrB   (readAddrB),
    .readDataB   (readDataB)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic r, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic [4:0] ra);
    if (r) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (we && wa == ra) return wd;
    return model[ra];
  endfunction

  // Drive one cycle. With use_tab set the table's expected values are pushed,
  // otherwise the reference model supplies them. The model is always updated.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic use_tab, input logic [31:0] ta, input logic [31:0] tb_v,
                       input string tag);
    exp_t e;
    reset       = r;
    writeEnable = we;
    writeAddr   = wa;
    writeData   = wd;
    readAddrA   = ra;
    readAddrB   = rb;
    e.tag = tag;
    if (use_tab) begin
      e.a = ta;
      e.b = tb_v;
    end else begin
      e.a = model_read(r, we, wa, wd, ra);
      e.b = model_read(r, we, wa, wd, rb);
    end
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: no expected entry for output cycle");
      return;
    end
    e = exp_q.pop_front();
    if (readDataA !== e.a) begin
      fails++;
      $display("FAIL %s portA: got %h expected %h", e.tag, readDataA, e.a);
    end
    checks++;
    if (readDataB !== e.b) begin
      fails++;
      $display("FAIL %s portB: got %h expected %h", e.tag, readDataB, e.b);
    end
  endtask

  task automatic mdrive(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                        input string tag);
    drive(r, we, wa, wd, ra, rb, 1'b0, 32'h0, 32'h0, tag);
  endtask

  initial begin
    vec_t vecs[11];
    vecs[0]  = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 32'h0,         32'h0,         "rst_write_lost"};
    vecs[1]  = '{1'b1, 5'd3, 32'h1234_5678, 5'd0, 5'd0, 32'h0,         32'h0,         "write_r3"};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,         5'd3, 5'd3, 32'h1234_5678, 32'h1234_5678, "read_r3"};
    vecs[3]  = '{1'b1, 5'd7, 32'h0000_0001, 5'd3, 5'd0, 32'h1234_5678, 32'h0,         "write_r7_one"};
    vecs[4]  = '{1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "bypass_r7"};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd3, 32'hA5A5_A5A5, 32'h1234_5678, "read_r7_r3"};
    vecs[6]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0,         32'h0,         "r0_bypass"};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 32'h0,         32'h0,         "r0_read"};
    vecs[8]  = '{1'b1, 5'd7, 32'h0000_0042, 5'd7, 5'd5, 32'h0000_0042, 32'h0,         "b2b_first"};
    vecs[9]  = '{1'b1, 5'd7, 32'h0000_0043, 5'd7, 5'd7, 32'h0000_0043, 32'h0000_0043, "b2b_second"};
    vecs[10] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd3, 32'h0000_0043, 32'h1234_5678, "b2b_last_wins"};

    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset held two cycles with a write pending; the write must be lost.
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b1, 32'h0, 32'h0, "reset_c1");
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b1, 32'h0, 32'h0, "reset_c2");

    for (int i = 0; i < 11; i++) begin
      drive(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb,
            1'b1, vecs[i].ea, vecs[i].eb, vecs[i].tag);
    end

    // Fill registers 1..31 while reading, then sweep the ports in opposite directions.
    for (int i = 1; i < 32; i++) begin
      mdrive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(32 - i), "fill");
    end
    for (int k = 0; k < 32; k++) begin
      mdrive(1'b0, 1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k), "sweep");
    end

    // Random mix against the reference model.
    for (int k = 0; k < 200; k++) begin
      mdrive(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "random");
    end

    // Refill, then a single reset cycle during a write to reg 9.
    for (int i = 1; i < 32; i++) begin
      mdrive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0, "refill");
    end
    drive(1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd4, 1'b1, 32'h0, 32'h0, "midrst");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd4, 1'b1, 32'h0, 32'h0, "post_rst_r9_r4");
    drive(1'b1 ^ 1'b1, 1'b1, 5'd4, 32'h0BAD_CAFE, 5'd9, 5'd4, 1'b1, 32'h0, 32'h0BAD_CAFE, "post_rst_bypass");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd9, 1'b1, 32'h0BAD_CAFE, 32'h0, "post_rst_stored");

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound, expected completion");
    $fatal(1, "timeout");
  end

endmodule
